// File: rtl/qkd_bank_scheduler_if.sv
// Slot-generator and record-RAM/host signals of the bank scheduler.
// The master modport is the scheduler side; the slave modport is the generator/RAM/host side.
interface qkd_bank_scheduler_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              slot_valid;
  logic [2:0]        slot_state;
  logic              gate;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [1:0]        bank_ready;
  logic [1:0]        bank_ack;

  modport master (
    input  slot_valid, slot_state, bank_ack,
    output gate, wr_en, wr_addr, wr_data, bank_ready
  );

  modport slave (
    output slot_valid, slot_state, bank_ack,
    input  gate, wr_en, wr_addr, wr_data, bank_ready
  );
endinterface

// File: rtl/qkd_bank_scheduler.sv
// Packs 3-bit slot codes into words of a ping-pong record RAM, closes each bank with a
// sequence-counter word and gates pulse emission off while no free bank is available.
module qkd_bank_scheduler #(
  parameter int unsigned SLOTS_PER_WORD = 10,
  parameter int unsigned BANK_DEPTH     = 16384,
  parameter int unsigned ADDR_W         = 15
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  qkd_bank_scheduler_if.master        bus,
  output logic [31:0]                 bank_count,
  output logic                        overflow,
  output logic [1:0]                  fsm_state
);

  localparam int unsigned PACK_W = 3 * SLOTS_PER_WORD;
  localparam int unsigned K_W    = $clog2(SLOTS_PER_WORD);
  localparam int unsigned OFF_W  = ADDR_W - 1;
  localparam logic [K_W-1:0]   LAST_K    = K_W'(SLOTS_PER_WORD - 1);
  localparam logic [OFF_W-1:0] LAST_DATA = OFF_W'(BANK_DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_HEADER = 2'd2,
    S_STALL  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic                bank, bank_n;
  logic [OFF_W-1:0]    offset, offset_n;
  logic [K_W-1:0]      k, k_n;
  logic [PACK_W-1:0]   packed_q, packed_n;
  logic                wr_en_n;
  logic [ADDR_W-1:0]   wr_addr_n;
  logic [31:0]         wr_data_n;
  logic [1:0]          ready_set, ready_n;
  logic [31:0]         count_n;
  logic                overflow_n;

  always_comb begin
    state_n    = state;
    bank_n     = bank;
    offset_n   = offset;
    k_n        = k;
    packed_n   = packed_q;
    wr_en_n    = 1'b0;
    wr_addr_n  = bus.wr_addr;
    wr_data_n  = bus.wr_data;
    ready_set  = '0;
    count_n    = bank_count;
    overflow_n = overflow;

    unique case (state)
      S_IDLE: begin
        if (enable) state_n = S_FILL;
      end
      S_FILL: begin
        if (!enable) begin
          state_n  = S_IDLE;
          k_n      = '0;
          packed_n = '0;
        end else if (bus.slot_valid) begin
          packed_n[3*k +: 3] = bus.slot_state;
          if (k == LAST_K) begin
            wr_en_n   = 1'b1;
            wr_addr_n = {bank, offset};
            wr_data_n = 32'(packed_n);
            k_n       = '0;
            packed_n  = '0;
            offset_n  = offset + 1'b1;
            if (offset == LAST_DATA) state_n = S_HEADER;
          end else begin
            k_n = k + 1'b1;
          end
        end
      end
      S_HEADER: begin
        // offset already sits on the bank's last word here
        wr_en_n         = 1'b1;
        wr_addr_n       = {bank, offset};
        wr_data_n       = bank_count;
        ready_set[bank] = 1'b1;
        count_n         = bank_count + 32'd1;
        bank_n          = ~bank;
        offset_n        = '0;
        if (!enable) begin
          state_n = S_IDLE;
        end else if (bus.bank_ready[~bank] && !bus.bank_ack[~bank]) begin
          state_n    = S_STALL;
          overflow_n = 1'b1;
        end else begin
          state_n = S_FILL;
        end
      end
      S_STALL: begin
        if (!enable) begin
          state_n  = S_IDLE;
          k_n      = '0;
          packed_n = '0;
        end else if (bus.bank_ack[bank]) begin
          state_n = S_FILL;
        end
      end
    endcase

    ready_n = (bus.bank_ready & ~bus.bank_ack) | ready_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      bank           <= 1'b0;
      offset         <= '0;
      k              <= '0;
      packed_q       <= '0;
      bus.gate       <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.wr_addr    <= '0;
      bus.wr_data    <= '0;
      bus.bank_ready <= '0;
      bank_count     <= '0;
      overflow       <= 1'b0;
    end else begin
      state          <= state_n;
      bank           <= bank_n;
      offset         <= offset_n;
      k              <= k_n;
      packed_q       <= packed_n;
      bus.gate       <= (state_n == S_FILL);
      bus.wr_en      <= wr_en_n;
      bus.wr_addr    <= wr_addr_n;
      bus.wr_data    <= wr_data_n;
      bus.bank_ready <= ready_n;
      bank_count     <= count_n;
      overflow       <= overflow_n;
    end
  end

  assign fsm_state = state;

endmodule
